// File: rtl/dmx_frame_tx_if.sv
// Channel-update bus feeding dmx_frame_tx.
//   pan, tilt           8-bit values for the two channels
//   pan_addr, tilt_addr 9-bit 0-based DMX channel addresses
//   ready               1-cycle strobe: all four fields are valid this cycle
// master drives the bus (pan/tilt calculator); slave receives it (the transmitter).
interface dmx_frame_tx_if;
  logic [7:0] pan;
  logic [8:0] pan_addr;
  logic [7:0] tilt;
  logic [8:0] tilt_addr;
  logic       ready;

  modport master (output pan, pan_addr, tilt, tilt_addr, ready);
  modport slave  (input  pan, pan_addr, tilt, tilt_addr, ready);
endinterface

// File: rtl/dmx_frame_tx.sv
// DMX512 frame transmitter.
// Sends a continuous stream of frames (BREAK, MAB, start code, NUM_CH slots).
// Only the pan and tilt channels carry data; every other slot transmits 0x00.
// Channel updates are double-buffered: they are captured into pending registers
// and copied to the active set only when a new BREAK begins, so a frame never
// mixes old and new values.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   enable       1 = frames back to back; 0 = finish current frame, then idle
//   cmd          channel-update bus (slave side)
//   dmx_out      registered serial line to the RS-485 driver, idle high
//   busy         high in every state except IDLE
//   frame_done   1-cycle pulse aligned with the final cycle of the last stop bit
module dmx_frame_tx #(
  parameter int CLKS_PER_BIT = 108,
  parameter int BREAK_BITS   = 25,
  parameter int MAB_BITS     = 3,
  parameter int NUM_CH       = 512
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  dmx_frame_tx_if.slave   cmd,
  output logic            dmx_out,
  output logic            busy,
  output logic            frame_done
);

  localparam int BREAK_CLKS = CLKS_PER_BIT * BREAK_BITS;
  localparam int MAB_CLKS   = CLKS_PER_BIT * MAB_BITS;
  localparam int TW         = $clog2(BREAK_CLKS);

  localparam logic [TW-1:0] BREAK_LAST = TW'(BREAK_CLKS - 1);
  localparam logic [TW-1:0] MAB_LAST   = TW'(MAB_CLKS - 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [9:0]    LAST_SLOT  = 10'(NUM_CH);
  localparam logic [3:0]    LAST_BIT   = 4'd10;

  typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_MAB, ST_SLOT} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [3:0]    bit_idx, bit_next;
  logic [9:0]    slot_idx, slot_next;
  logic [9:0]    shreg, shreg_next;
  logic          line_next, done_next, enter_break;

  logic [7:0] pend_pan, pend_tilt, act_pan, act_tilt;
  logic [8:0] pend_pan_addr, pend_tilt_addr, act_pan_addr, act_tilt_addr;
  logic       pend_valid;
  logic [7:0] next_byte;

  // Byte for slot slot_idx+1, i.e. channel address slot_idx. Pan is tested
  // first so it wins when both addresses collide. Addresses >= NUM_CH are
  // never reached because slot_idx stops at NUM_CH-1 when this is used.
  always_comb begin
    next_byte = 8'h00;
    if (slot_idx == {1'b0, act_pan_addr})       next_byte = act_pan;
    else if (slot_idx == {1'b0, act_tilt_addr}) next_byte = act_tilt;
  end

  assign busy = (state != ST_IDLE);

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a variable unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_next  = state;
    timer_next  = timer + 1'b1;
    bit_next    = bit_idx;
    slot_next   = slot_idx;
    shreg_next  = shreg;
    line_next   = 1'b1;
    done_next   = 1'b0;
    enter_break = 1'b0;

    unique case (state)
      ST_IDLE: begin
        timer_next = '0;
        if (enable) begin
          state_next  = ST_BREAK;
          enter_break = 1'b1;
        end
      end

      ST_BREAK: begin
        line_next = 1'b0;
        if (timer == BREAK_LAST) begin
          state_next = ST_MAB;
          timer_next = '0;
        end
      end

      ST_MAB: begin
        if (timer == MAB_LAST) begin
          state_next = ST_SLOT;
          timer_next = '0;
          bit_next   = '0;
          slot_next  = '0;
          shreg_next = {2'b11, 8'h00};  // start code
        end
      end

      ST_SLOT: begin
        // Bit 0 is the start bit; bits 1..10 come from the LSB of the shift
        // register, whose top two bits supply the stop bits.
        line_next = (bit_idx == 4'd0) ? 1'b0 : shreg[0];
        if (timer == BIT_LAST) begin
          timer_next = '0;
          if (bit_idx != 4'd0) shreg_next = {1'b1, shreg[9:1]};
          if (bit_idx == LAST_BIT) begin
            bit_next = '0;
            if (slot_idx == LAST_SLOT) begin
              done_next = 1'b1;
              slot_next = '0;
              if (enable) begin
                state_next  = ST_BREAK;
                enter_break = 1'b1;
              end else begin
                state_next = ST_IDLE;
              end
            end else begin
              slot_next  = slot_idx + 10'd1;
              shreg_next = {2'b11, next_byte};
            end
          end else begin
            bit_next = bit_idx + 4'd1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      timer          <= '0;
      bit_idx        <= '0;
      slot_idx       <= '0;
      shreg          <= '0;
      dmx_out        <= 1'b1;
      frame_done     <= 1'b0;
      pend_pan       <= '0;
      pend_pan_addr  <= '0;
      pend_tilt      <= '0;
      pend_tilt_addr <= '0;
      pend_valid     <= 1'b0;
      act_pan        <= '0;
      act_pan_addr   <= '0;
      act_tilt       <= '0;
      act_tilt_addr  <= '0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      bit_idx    <= bit_next;
      slot_idx   <= slot_next;
      shreg      <= shreg_next;
      dmx_out    <= line_next;
      frame_done <= done_next;

      // The copy reads pending before this edge, so a ready arriving on the
      // BREAK-entry cycle stays pending for the following frame.
      if (enter_break && pend_valid) begin
        act_pan       <= pend_pan;
        act_pan_addr  <= pend_pan_addr;
        act_tilt      <= pend_tilt;
        act_tilt_addr <= pend_tilt_addr;
        pend_valid    <= 1'b0;
      end
      if (cmd.ready) begin
        pend_pan       <= cmd.pan;
        pend_pan_addr  <= cmd.pan_addr;
        pend_tilt      <= cmd.tilt;
        pend_tilt_addr <= cmd.tilt_addr;
        pend_valid     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmx_frame_tx.sv
// Self-checking bench for dmx_frame_tx with small timing parameters.
// Stimulus pushes the expected slot bytes of each frame into a queue; an
// independent monitor decodes dmx_out (break/MAB lengths, framing, data bytes,
// frame_done alignment) and compares against the queue head.
module tb_dmx_frame_tx;
  localparam int CPB       = 4;
  localparam int BRK       = 23;
  localparam int MAB       = 3;
  localparam int NCH       = 4;
  localparam int BREAK_CYC = CPB * BRK;  // 92
  localparam int MAB_CYC   = CPB * MAB;  // 12

  typedef logic [NCH:0][7:0] frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic dmx_out, busy, frame_done;

  dmx_frame_tx_if bus ();

  dmx_frame_tx #(
    .CLKS_PER_BIT(CPB),
    .BREAK_BITS  (BRK),
    .MAB_BITS    (MAB),
    .NUM_CH      (NCH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cmd       (bus),
    .dmx_out   (dmx_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int     n_total  = 0;
  int     n_pass   = 0;
  int     fd_seen  = 0;
  int     frame_no = 0;
  bit     aborted;
  frame_t exp_q[$];

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic frame_t mk(input logic [7:0] s0, s1, s2, s3, s4);
    frame_t f;
    f[0] = s0; f[1] = s1; f[2] = s2; f[3] = s3; f[4] = s4;
    return f;
  endfunction

  always @(negedge clk) if (frame_done === 1'b1) fd_seen++;

  // ---------------- monitor ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (reset !== 1'b0) aborted = 1'b1;
    end
  endtask

  // Entered on the first negedge that shows the BREAK low.
  task automatic decode_frame();
    int          lo, hi;
    logic [10:0] bits;
    frame_t      got, exp;
    logic [NCH:0] framing_ok;
    logic        fd_end;
    aborted = 1'b0;
    lo = 0; hi = 0; fd_end = 1'b0; bits = '0;
    while (dmx_out === 1'b0 && lo < 1000) begin lo++; step(1); if (aborted) return; end
    while (dmx_out === 1'b1 && hi < 1000) begin hi++; step(1); if (aborted) return; end
    for (int s = 0; s <= NCH; s++) begin
      for (int b = 0; b < 11; b++) begin
        step(2); if (aborted) return;
        bits[b] = dmx_out;                       // mid-bit sample
        step(1); if (aborted) return;
        if (s == NCH && b == 10) fd_end = frame_done;  // final cycle of last stop bit
        step(1); if (aborted) return;
      end
      got[s]        = bits[8:1];
      framing_ok[s] = (bits[0] == 1'b0) && (bits[10:9] == 2'b11);
    end
    frame_no++;
    check($sformatf("f%0d_break_cycles", frame_no), lo, BREAK_CYC);
    check($sformatf("f%0d_mab_cycles", frame_no), hi, MAB_CYC);
    check($sformatf("f%0d_frame_done_at_end", frame_no), fd_end, 1);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL f%0d_unexpected_frame: got a frame, expected none", frame_no);
    end else begin
      exp = exp_q.pop_front();
      for (int s = 0; s <= NCH; s++) begin
        check($sformatf("f%0d_slot%0d_framing", frame_no, s), framing_ok[s], 1);
        check($sformatf("f%0d_slot%0d_byte", frame_no, s), got[s], exp[s]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    forever begin
      if (reset !== 1'b0)        @(negedge clk);
      else if (dmx_out === 1'b0) decode_frame();
      else                       @(negedge clk);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] p, input logic [8:0] pa,
                        input logic [7:0] t, input logic [8:0] ta);
    bus.pan = p; bus.pan_addr = pa; bus.tilt = t; bus.tilt_addr = ta;
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    check(name, busy, 0);
  endtask

  initial begin
    bus.pan = '0; bus.pan_addr = '0; bus.tilt = '0; bus.tilt_addr = '0; bus.ready = 1'b0;
    cycles(3);
    check("rst_dmx_out", dmx_out, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    cycles(2);
    check("idle_dmx_out", dmx_out, 1);
    check("idle_busy", busy, 0);

    // Frame 1: nothing pending, all slots zero. Counting below is in state
    // cycles, with BREAK entered on the edge after enable goes high (cycle 0).
    exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    enable = 1'b1;
    cycles(150);                                  // cycle 149, inside frame 1
    check("t1_busy", busy, 1);
    strobe(8'hA5, 9'd1, 8'h3C, 9'd3);             // frame 1 unaffected
    exp_q.push_back(mk(8'h00, 8'h00, 8'hA5, 8'h00, 8'h3C));
    cycles(324);                                  // cycle 474, inside frame 2
    strobe(8'h11, 9'd2, 8'h22, 9'd2);             // address collision: pan wins
    exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h11, 8'h00));
    cycles(375);                                  // cycle 850: frame 3, slot 2
    enable = 1'b0;
    wait_idle("t5_idle");
    cycles(3);
    check("t5_dmx_out", dmx_out, 1);
    check("t5_busy", busy, 0);
    check("t5_frame_done_count", fd_seen, 3);

    // Pending set while idle; a second ready lands on the BREAK-entry edge.
    strobe(8'h5A, 9'd0, 8'hC3, 9'd4);             // tilt_addr 4 is past the last slot
    cycles(3);
    exp_q.push_back(mk(8'h00, 8'h5A, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(mk(8'h00, 8'h99, 8'h00, 8'h00, 8'h77));
    enable = 1'b1;
    strobe(8'h77, 9'd3, 8'h99, 9'd0);
    cycles(424);                                  // inside frame 5
    enable = 1'b0;
    wait_idle("t4_idle");
    cycles(3);
    check("t4_frame_done_count", fd_seen, 5);

    // Reset during a data bit of slot 2 (a zero byte, so the line is low).
    strobe(8'h81, 9'd0, 8'h42, 9'd3);
    enable = 1'b1;
    cycles(51);                                   // cycle 50
    strobe(8'hEE, 9'd1, 8'hDD, 9'd2);             // left pending, dropped by reset
    cycles(154);                                  // cycle 205: slot 2, data bit
    check("t6_line_low_before_reset", dmx_out, 0);
    reset = 1'b1;
    cycles(1);
    check("t6_rst_dmx_out", dmx_out, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_frame_done", frame_done, 0);
    exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    cycles(1);
    reset = 1'b0;                                 // enable still high
    cycles(100);
    enable = 1'b0;
    wait_idle("t6_idle");
    cycles(10);
    check("end_dmx_out", dmx_out, 1);
    check("end_frame_done_count", fd_seen, 6);
    check("end_frames_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: still running after 20000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
